// File: rtl/lsu_bus_master.sv
// Load/store bus master: one CPU load/store at a time over a valid/ready memory channel.
// Optional define MISALIGN_TRAP_EN: misaligned h/w accesses complete with ls_err and issue no request.
module lsu_bus_master #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ls_valid,
  output logic            ls_ready,
  input  logic            ls_we,
  input  logic [2:0]      ls_ctr,
  input  logic [AW-1:0]   ls_addr,
  input  logic [DW-1:0]   ls_wdata,
  output logic [DW-1:0]   ls_rdata,
  output logic            ls_done,
  output logic            ls_err,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_req_we,
  output logic [AW-1:0]   mem_req_addr,
  output logic [DW-1:0]   mem_req_wdata,
  output logic [DW/8-1:0] mem_req_wstrb,
  input  logic            mem_resp_valid,
  input  logic [DW-1:0]   mem_resp_data,
  input  logic            mem_resp_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            we_q, we_d;
  logic [2:0]      ctr_q, ctr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            trap_s;

  function automatic logic is_legal(input logic [2:0] ctr);
    case (ctr)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: is_legal = 1'b1;
      default:                                 is_legal = 1'b0;
    endcase
  endfunction

  // Offset actually used: halfwords drop o[0], words ignore the offset entirely.
  function automatic logic [1:0] eff_off(input logic [1:0] size, input logic [1:0] o);
    case (size)
      2'b00:   eff_off = o;
      2'b01:   eff_off = {o[1], 1'b0};
      default: eff_off = 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   store_data = {4{wd[7:0]}};
      2'b01:   store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] o);
    case (size)
      2'b00:   store_strb = 4'b0001 << eff_off(size, o);
      2'b01:   store_strb = 4'b0011 << eff_off(size, o);
      default: store_strb = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] fmt_load(input logic [2:0] ctr, input logic [1:0] o,
                                           input logic [31:0] data);
    logic [31:0] s;
    s = data >> {eff_off(ctr[1:0], o), 3'b000};
    case (ctr)
      3'b000:  fmt_load = {{24{s[7]}}, s[7:0]};
      3'b001:  fmt_load = {{16{s[15]}}, s[15:0]};
      3'b010:  fmt_load = data;
      3'b100:  fmt_load = {24'h000000, s[7:0]};
      3'b101:  fmt_load = {16'h0000, s[15:0]};
      default: fmt_load = 32'h00000000;
    endcase
  endfunction

`ifdef MISALIGN_TRAP_EN
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] o);
    case (size)
      2'b01:   is_misaligned = o[0];
      2'b10:   is_misaligned = (o != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

  assign trap_s = is_misaligned(ls_ctr[1:0], ls_addr[1:0]);
`else
  assign trap_s = 1'b0;
`endif

  // State and captured-transaction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      ctr_q   <= 3'b000;
      addr_q  <= {AW{1'b0}};
      wdata_q <= {DW{1'b0}};
      rdata_q <= {DW{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      ctr_q   <= ctr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state and capture logic.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    ctr_d   = ctr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (ls_valid) begin
          we_d    = ls_we;
          ctr_d   = ls_ctr;
          addr_d  = ls_addr;
          wdata_d = ls_wdata;
          rdata_d = {DW{1'b0}};
          if (!is_legal(ls_ctr) || trap_s) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = ST_REQ;
            err_d   = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_RESP: begin
        if (mem_resp_valid) begin
          state_d = ST_DONE;
          rdata_d = we_q ? {DW{1'b0}} : fmt_load(ctr_q, addr_q[1:0], mem_resp_data);
          err_d   = mem_resp_err;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode only registered state, so they are glitch-free and zero outside their phase.
  assign ls_ready      = (state_q == ST_IDLE);
  assign ls_done       = (state_q == ST_DONE);
  assign ls_err        = ls_done & err_q;
  assign ls_rdata      = ls_done ? rdata_q : {DW{1'b0}};
  assign mem_req_valid = (state_q == ST_REQ);
  assign mem_req_we    = mem_req_valid & we_q;
  assign mem_req_addr  = mem_req_valid ? {addr_q[AW-1:2], 2'b00} : {AW{1'b0}};
  assign mem_req_wdata = mem_req_valid ? store_data(ctr_q[1:0], wdata_q) : {DW{1'b0}};
  assign mem_req_wstrb = (mem_req_valid && we_q) ? store_strb(ctr_q[1:0], addr_q[1:0]) : 4'b0000;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Self-checking bench for lsu_bus_master: directed spec cases plus randomized traffic against a byte-lane model.
module tb_lsu_bus_master;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ls_valid = 1'b0, ls_ready, ls_we = 1'b0, ls_done, ls_err;
  logic [2:0]  ls_ctr = 3'b000;
  logic [31:0] ls_addr = 32'h0, ls_wdata = 32'h0, ls_rdata;
  logic        mem_req_valid, mem_req_ready = 1'b0, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid = 1'b0, mem_resp_err = 1'b0;
  logic [31:0] mem_resp_data = 32'h0;

  int checks = 0;
  int errors = 0;

  // observations from the last run_txn
  logic        o_issued, o_stable, o_done, o_err, o_we, o_after_done, o_after_ready;
  logic [31:0] o_addr, o_wdata, o_rdata;
  logic [3:0]  o_strb;
  int          o_lat;

  lsu_bus_master dut (
    .clk(clk), .rst_n(rst_n), .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_we(ls_we),
    .ls_ctr(ls_ctr), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_rdata(ls_rdata),
    .ls_done(ls_done), .ls_err(ls_err), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_err(mem_resp_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (byte-lane view) ----------------
  function automatic int m_size(input logic [2:0] ctr);
    return (ctr[1:0] == 2'b00) ? 1 : (ctr[1:0] == 2'b01) ? 2 : 4;
  endfunction
  function automatic bit m_legal(input logic [2:0] ctr);
    return (ctr == 3'd0 || ctr == 3'd1 || ctr == 3'd2 || ctr == 3'd4 || ctr == 3'd5);
  endfunction
  function automatic bit m_issues(input logic [2:0] ctr, input logic [31:0] addr);
    int off;
    off = int'(addr[1:0]);
    if (!m_legal(ctr)) return 1'b0;
`ifdef MISALIGN_TRAP_EN
    if ((off % m_size(ctr)) != 0) return 1'b0;
`endif
    return 1'b1;
  endfunction
  function automatic int m_start(input logic [2:0] ctr, input logic [31:0] addr);
    return (int'(addr[1:0]) / m_size(ctr)) * m_size(ctr);
  endfunction
  function automatic logic [3:0] m_strb(input logic we, input logic [2:0] ctr, input logic [31:0] addr);
    logic [3:0] s;
    s = 4'b0000;
    for (int i = 0; i < 4; i++)
      if (we && i >= m_start(ctr, addr) && i < m_start(ctr, addr) + m_size(ctr)) s[i] = 1'b1;
    return s;
  endfunction
  function automatic logic [31:0] m_wdata(input logic [2:0] ctr, input logic [31:0] wd);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = wd[8*(i % m_size(ctr)) +: 8];
    return v;
  endfunction
  function automatic logic [31:0] m_load(input logic [2:0] ctr, input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] v;
    int n, st;
    n = m_size(ctr);
    st = m_start(ctr, addr);
    v = 32'h0;
    for (int j = 0; j < n; j++) v[8*j +: 8] = rd[8*(st+j) +: 8];
    if (!ctr[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8*n));
    return v;
  endfunction

  // ---------------- driver / responder ----------------
  task automatic run_txn(input logic we, input logic [2:0] ctr, input logic [31:0] addr, wd, rd,
                         input logic rerr, input int rdy_dly, rsp_dly, input logic stray);
    int req_cnt, rsp_cnt, phase;
    o_issued = 1'b0; o_stable = 1'b1; o_done = 1'b0; o_err = 1'b0; o_rdata = 32'h0;
    o_lat = -1; o_after_done = 1'b0; o_after_ready = 1'b0;
    o_addr = 32'h0; o_wdata = 32'h0; o_strb = 4'h0; o_we = 1'b0;
    req_cnt = 0; rsp_cnt = 0; phase = 0;
    @(negedge clk);
    ls_valid = 1'b1; ls_we = we; ls_ctr = ctr; ls_addr = addr; ls_wdata = wd;
    @(posedge clk); #1;
    ls_valid = 1'b0; ls_we = $urandom_range(0, 1); ls_ctr = 3'($urandom_range(0, 7));
    ls_addr = $urandom; ls_wdata = $urandom;
    for (int k = 1; k <= 60; k++) begin
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
      mem_resp_data = $urandom; mem_resp_err = 1'($urandom_range(0, 1));
      if (ls_done) begin
        o_done = 1'b1; o_lat = k; o_rdata = ls_rdata; o_err = ls_err;
        break;
      end
      if (phase == 0 && mem_req_valid) begin
        if (!o_issued) begin
          o_issued = 1'b1; o_addr = mem_req_addr; o_we = mem_req_we;
          o_wdata = mem_req_wdata; o_strb = mem_req_wstrb;
        end else if (mem_req_addr !== o_addr || mem_req_we !== o_we ||
                     mem_req_wdata !== o_wdata || mem_req_wstrb !== o_strb) begin
          o_stable = 1'b0;
        end
        req_cnt++;
        if (req_cnt > rdy_dly) begin
          mem_req_ready = 1'b1; phase = 1;
        end else if (stray) begin
          mem_resp_valid = 1'b1;
        end
      end else if (phase == 1) begin
        rsp_cnt++;
        if (rsp_cnt > rsp_dly) begin
          mem_resp_valid = 1'b1; mem_resp_data = rd; mem_resp_err = rerr; phase = 2;
        end
      end
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    if (o_done) begin
      @(posedge clk); #1;
      o_after_done = ls_done; o_after_ready = ls_ready;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ls_ready, ls_done, ls_err, ls_rdata, mem_req_valid, mem_req_we, mem_req_addr,
         mem_req_wdata, mem_req_wstrb} !== {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0}) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b done=%b err=%b rdata=%h req_valid=%b addr=%h wstrb=%b, required ready=1 others 0",
               ls_ready, ls_done, ls_err, ls_rdata, mem_req_valid, mem_req_addr, mem_req_wstrb);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_lw();
    run_txn(1'b0, 3'b010, 32'h80000004, 32'h0, 32'hDEADBEEF, 1'b0, 0, 0, 1'b0);
    checks++;
    if (o_addr !== 32'h80000004 || o_strb !== 4'b0000 || o_we !== 1'b0) begin
      errors++; $display("FAIL lw_req: addr=%h wstrb=%b we=%b, required 80000004 0000 0", o_addr, o_strb, o_we);
    end
    checks++;
    if (o_lat !== 3 || o_rdata !== 32'hDEADBEEF || o_err !== 1'b0) begin
      errors++; $display("FAIL lw_done: lat=%0d rdata=%h err=%b, required 3 deadbeef 0", o_lat, o_rdata, o_err);
    end
    checks++;
    if (o_after_done !== 1'b0 || o_after_ready !== 1'b1) begin
      errors++; $display("FAIL lw_pulse: done_next=%b ready_next=%b, required 0 1", o_after_done, o_after_ready);
    end
  endtask

  task automatic test_byte_loads();
    run_txn(1'b0, 3'b000, 32'h80000003, 32'h0, 32'h80112233, 1'b0, 0, 0, 1'b0);
    checks++;
    if (o_rdata !== 32'hFFFFFF80) begin
      errors++; $display("FAIL lb_sext: rdata=%h, required ffffff80", o_rdata);
    end
    run_txn(1'b0, 3'b100, 32'h80000003, 32'h0, 32'h80112233, 1'b0, 0, 0, 1'b0);
    checks++;
    if (o_rdata !== 32'h00000080) begin
      errors++; $display("FAIL lbu_zext: rdata=%h, required 00000080", o_rdata);
    end
  endtask

  task automatic test_store_half();
    run_txn(1'b1, 3'b001, 32'h80000002, 32'h0000ABCD, 32'h12345678, 1'b0, 0, 0, 1'b0);
    checks++;
    if (o_wdata !== 32'hABCDABCD || o_strb !== 4'b1100 || o_we !== 1'b1 || o_addr !== 32'h80000000) begin
      errors++; $display("FAIL sh_req: wdata=%h wstrb=%b we=%b addr=%h, required abcdabcd 1100 1 80000000",
                         o_wdata, o_strb, o_we, o_addr);
    end
    checks++;
    if (o_done !== 1'b1 || o_err !== 1'b0 || o_rdata !== 32'h0) begin
      errors++; $display("FAIL sh_done: done=%b err=%b rdata=%h, required 1 0 0", o_done, o_err, o_rdata);
    end
  endtask

  task automatic test_stall();
    run_txn(1'b1, 3'b000, 32'h80000001, 32'h000000A5, 32'h0, 1'b0, 5, 0, 1'b1);
    checks++;
    if (o_stable !== 1'b1 || o_strb !== 4'b0010 || o_wdata !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL stall_stable: stable=%b wstrb=%b wdata=%h, required 1 0010 a5a5a5a5",
                         o_stable, o_strb, o_wdata);
    end
    checks++;
    if (o_lat !== 8) begin
      errors++; $display("FAIL stall_latency: lat=%0d, required 8 (stray resp in REQ ignored)", o_lat);
    end
  endtask

  task automatic test_misalign_word();
    run_txn(1'b0, 3'b010, 32'h80000001, 32'h0, 32'hCAFEF00D, 1'b0, 0, 0, 1'b0);
`ifdef MISALIGN_TRAP_EN
    checks++;
    if (o_issued !== 1'b0 || o_lat !== 1 || o_err !== 1'b1) begin
      errors++; $display("FAIL lw_trap: issued=%b lat=%0d err=%b, required 0 1 1", o_issued, o_lat, o_err);
    end
`else
    checks++;
    if (o_addr !== 32'h80000000 || o_rdata !== 32'hCAFEF00D || o_err !== 1'b0 || o_lat !== 3) begin
      errors++; $display("FAIL lw_misalign: addr=%h rdata=%h err=%b lat=%0d, required 80000000 cafef00d 0 3",
                         o_addr, o_rdata, o_err, o_lat);
    end
`endif
  endtask

  task automatic test_illegal_and_buserr();
    run_txn(1'b1, 3'b111, 32'h80000000, 32'h1, 32'h0, 1'b0, 0, 0, 1'b0);
    checks++;
    if (o_issued !== 1'b0 || o_lat !== 1 || o_err !== 1'b1) begin
      errors++; $display("FAIL illegal_ctr: issued=%b lat=%0d err=%b, required 0 1 1", o_issued, o_lat, o_err);
    end
    run_txn(1'b0, 3'b010, 32'h80000010, 32'h0, 32'h0BADF00D, 1'b1, 1, 2, 1'b0);
    checks++;
    if (o_err !== 1'b1 || o_lat !== 6) begin
      errors++; $display("FAIL bus_err: err=%b lat=%0d, required 1 6", o_err, o_lat);
    end
  endtask

  task automatic test_reset_mid();
    logic saw_done;
    @(negedge clk);
    ls_valid = 1'b1; ls_we = 1'b0; ls_ctr = 3'b010; ls_addr = 32'h80000000;
    @(posedge clk); #1;
    ls_valid = 1'b0; mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ls_ready !== 1'b1 || ls_done !== 1'b0 || ls_err !== 1'b0 || mem_req_valid !== 1'b0 || ls_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_mid: ready=%b done=%b err=%b req_valid=%b rdata=%h, required 1 0 0 0 0",
                         ls_ready, ls_done, ls_err, mem_req_valid, ls_rdata);
    end
    mem_resp_valid = 1'b1; mem_resp_data = 32'h11111111;
    @(negedge clk); rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ls_done) saw_done = 1'b1;
    end
    mem_resp_valid = 1'b0;
    checks++;
    if (saw_done !== 1'b0) begin
      errors++; $display("FAIL reset_no_done: ls_done seen=%b, required 0", saw_done);
    end
    run_txn(1'b0, 3'b101, 32'h80000002, 32'h0, 32'hF00D0000, 1'b0, 0, 0, 1'b0);
    checks++;
    if (o_rdata !== 32'h0000F00D || o_err !== 1'b0 || o_lat !== 3) begin
      errors++; $display("FAIL lhu_after_reset: rdata=%h err=%b lat=%0d, required 0000f00d 0 3", o_rdata, o_err, o_lat);
    end
  endtask

  task automatic test_random();
    logic we, rerr, stray, iss;
    logic [2:0] ctr;
    logic [31:0] addr, wd, rd, exp_rd;
    int rdy, rsp, exp_lat;
    for (int n = 0; n < 200; n++) begin
      we = 1'($urandom_range(0, 1)); ctr = 3'($urandom_range(0, 7)); addr = $urandom;
      wd = $urandom; rd = $urandom; rerr = ($urandom_range(0, 7) == 0);
      rdy = $urandom_range(0, 3); rsp = $urandom_range(0, 3); stray = 1'($urandom_range(0, 1));
      run_txn(we, ctr, addr, wd, rd, rerr, rdy, rsp, stray);
      iss = m_issues(ctr, addr);
      exp_lat = iss ? 3 + rdy + rsp : 1;
      exp_rd = (!iss || we) ? 32'h0 : m_load(ctr, addr, rd);
      checks++;
      if (o_issued !== iss) begin
        errors++; $display("FAIL rnd_issue #%0d: issued=%b, required %b (ctr=%b addr=%h)", n, o_issued, iss, ctr, addr);
      end
      if (iss) begin
        checks++;
        if (o_addr !== {addr[31:2], 2'b00} || o_we !== we || o_strb !== m_strb(we, ctr, addr) || o_stable !== 1'b1 ||
            (we && o_wdata !== m_wdata(ctr, wd))) begin
          errors++;
          $display("FAIL rnd_req #%0d: addr=%h we=%b wstrb=%b wdata=%h stable=%b, required %h %b %b %h 1",
                   n, o_addr, o_we, o_strb, o_wdata, o_stable, {addr[31:2], 2'b00}, we,
                   m_strb(we, ctr, addr), m_wdata(ctr, wd));
        end
      end
      checks++;
      if (o_done !== 1'b1 || o_lat !== exp_lat || o_rdata !== exp_rd || o_err !== (iss ? rerr : 1'b1)) begin
        errors++;
        $display("FAIL rnd_done #%0d: done=%b lat=%0d rdata=%h err=%b, required 1 %0d %h %b (ctr=%b addr=%h we=%b)",
                 n, o_done, o_lat, o_rdata, o_err, exp_lat, exp_rd, iss ? rerr : 1'b1, ctr, addr, we);
      end
      checks++;
      if (o_after_done !== 1'b0 || o_after_ready !== 1'b1) begin
        errors++; $display("FAIL rnd_pulse #%0d: done_next=%b ready_next=%b, required 0 1", n, o_after_done, o_after_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_byte_loads();
    test_store_half();
    test_stall();
    test_misalign_word();
    test_illegal_and_buserr();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
